// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: PC width, reset vector and the ID-stage control-flow encoding.
// Helper br_offset turns a word-unit branch immediate into a sign-extended byte offset.
package pipeline_pkg;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] PC_RESET = 32'h0000_3000;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_COND = 2'd1,
      BR_J    = 2'd2,
      BR_JR   = 2'd3
   } br_type_e;

   function automatic logic [PC_W-1:0] br_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection: purely combinational, zero latency, no backpressure (the stall is applied by the caller).
// Redirect targets are relative to pc_d + 4 because the delay-slot instruction is already fetched.
module npc_calc
   import pipeline_pkg::*;
(
   input  logic [PC_W-1:0] pc_f,
   input  logic [PC_W-1:0] pc_d,
   input  logic [1:0]      br_type,
   input  logic            br_true,
   input  logic [15:0]     imm16,
   input  logic [25:0]     index26,
   input  logic [PC_W-1:0] jr_target,
   output logic [PC_W-1:0] npc
);

   logic [PC_W-1:0] pc_d4;

   assign pc_d4 = pc_d + 32'd4;

   always_comb begin
      npc = pc_f + 32'd4;
      case (br_type_e'(br_type))
         BR_COND: if (br_true) npc = pc_d4 + br_offset(imm16);
         BR_J:    npc = {pc_d4[PC_W-1:PC_W-4], index26, 2'b00};
         BR_JR:   npc = jr_target;
         default: ;
      endcase
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch/decode PC registers: one-edge redirect latency, stall freezes both PCs and outranks any redirect.
// Optional sticky fetch-misalignment flag is built only when PC_ALIGN_CHECK_EN is defined.
module pc_unit
   import pipeline_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic [1:0]      br_type,
   input  logic            br_true,
   input  logic [15:0]     imm16,
   input  logic [25:0]     index26,
   input  logic [PC_W-1:0] jr_target,
   output logic [PC_W-1:0] pc_F,
   output logic [PC_W-1:0] pc_D,
   output logic [PC_W-1:0] pc8_D,
   output logic            pc_misalign
);

   logic [PC_W-1:0] pc_f_q, pc_f_d;
   logic [PC_W-1:0] pc_d_q, pc_d_d;
   logic [PC_W-1:0] npc;

   npc_calc u_npc_calc (
      .pc_f      (pc_f_q),
      .pc_d      (pc_d_q),
      .br_type   (br_type),
      .br_true   (br_true),
      .imm16     (imm16),
      .index26   (index26),
      .jr_target (jr_target),
      .npc       (npc)
   );

   always_comb begin
      pc_f_d = pc_f_q;
      pc_d_d = pc_d_q;
      if (!stall) begin
         pc_f_d = npc;
         pc_d_d = pc_f_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_f_q <= PC_RESET;
         pc_d_q <= '0;
      end else begin
         pc_f_q <= pc_f_d;
         pc_d_q <= pc_d_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   // Unaligned target still loads into pc_F; only the flag records it.
   always_comb misalign_d = misalign_q | (!stall && (npc[1:0] != 2'b00));

   always_ff @(posedge clk) begin
      if (!reset) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end

   assign pc_misalign = misalign_q;
`else
   assign pc_misalign = 1'b0;
`endif

   assign pc_F  = pc_f_q;
   assign pc_D  = pc_d_q;
   assign pc8_D = pc_d_q + 32'd8;

endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: expected PCs are queued as each edge is driven and popped after it.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  br_type;
   logic        br_true;
   logic [15:0] imm16;
   logic [25:0] index26;
   logic [31:0] jr_target;
   logic [31:0] pc_F, pc_D, pc8_D;
   logic        pc_misalign;

`ifdef PC_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] f;
      logic [31:0] d;
      logic        mis;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        st;
      logic [1:0]  bt;
      logic        brt;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [31:0] jr;
      logic [31:0] ef;
      logic [31:0] ed;
      logic        em;
   } stim_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   pc_unit dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .br_type     (br_type),
      .br_true     (br_true),
      .imm16       (imm16),
      .index26     (index26),
      .jr_target   (jr_target),
      .pc_F        (pc_F),
      .pc_D        (pc_D),
      .pc8_D       (pc8_D),
      .pc_misalign (pc_misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one edge's inputs, record what the outputs must be after it, then step past the edge.
   task automatic apply(input stim_t s);
      exp_t e;
      reset     = s.rst;
      stall     = s.st;
      br_type   = s.bt;
      br_true   = s.brt;
      imm16     = s.imm;
      index26   = s.idx;
      jr_target = s.jr;
      e.f = s.ef; e.d = s.ed; e.mis = s.em;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b0, 1'b1, 2'd3, 1'b1, 16'h0001, 26'h3FF_FFFF, 32'h1234_5679, 32'h0000_3000, 32'h0, 1'b0});
      s.push_back('{1'b0, 1'b1, 2'd3, 1'b1, 16'h0001, 26'h3FF_FFFF, 32'h1234_5679, 32'h0000_3000, 32'h0, 1'b0});
      // Reset released while stalled on an unaligned jr: everything must hold.
      s.push_back('{1'b1, 1'b1, 2'd3, 1'b0, 16'h0000, 26'h0, 32'h0000_5555, 32'h0000_3000, 32'h0, 1'b0});
      foreach (s[i]) begin
         apply(s[i]);
         e = sb.pop_front();
         checks++; if (pc_F !== e.f) begin errors++; $display("FAIL reset_pc_F step%0d got=%h exp=%h", i, pc_F, e.f); end
         checks++; if (pc_D !== e.d) begin errors++; $display("FAIL reset_pc_D step%0d got=%h exp=%h", i, pc_D, e.d); end
         checks++; if (pc_misalign !== e.mis) begin errors++; $display("FAIL reset_misalign step%0d got=%b exp=%b", i, pc_misalign, e.mis); end
      end
   endtask

   task automatic test_seq();
      stim_t s;
      exp_t  e;
      for (int i = 0; i < 4; i++) begin
         s = '{1'b1, 1'b0, 2'd0, 1'b1, 16'hFFFC, 26'h0, 32'h0000_3402, 32'h3004 + 32'(4 * i), 32'h3000 + 32'(4 * i), 1'b0};
         apply(s);
         e = sb.pop_front();
         checks++; if (pc_F !== e.f) begin errors++; $display("FAIL seq_pc_F step%0d got=%h exp=%h", i, pc_F, e.f); end
         checks++; if (pc_D !== e.d) begin errors++; $display("FAIL seq_pc_D step%0d got=%h exp=%h", i, pc_D, e.d); end
         checks++; if (pc8_D !== e.d + 32'd8) begin errors++; $display("FAIL seq_pc8_D step%0d got=%h exp=%h", i, pc8_D, e.d + 32'd8); end
         checks++; if (pc_misalign !== e.mis) begin errors++; $display("FAIL seq_misalign step%0d got=%b exp=%b", i, pc_misalign, e.mis); end
      end
   endtask

   task automatic test_branch();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_3014, 32'h0000_3010, 1'b0});
      // 0x3010 + 4 - 16 = 0x3004
      s.push_back('{1'b1, 1'b0, 2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 32'h0000_3004, 32'h0000_3014, 1'b0});
      s.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 32'h0000_3008, 32'h0000_3004, 1'b0});
      foreach (s[i]) begin
         apply(s[i]);
         e = sb.pop_front();
         checks++; if (pc_F !== e.f) begin errors++; $display("FAIL branch_pc_F step%0d got=%h exp=%h", i, pc_F, e.f); end
         checks++; if (pc_D !== e.d) begin errors++; $display("FAIL branch_pc_D step%0d got=%h exp=%h", i, pc_D, e.d); end
         checks++; if (pc8_D !== e.d + 32'd8) begin errors++; $display("FAIL branch_pc8_D step%0d got=%h exp=%h", i, pc8_D, e.d + 32'd8); end
      end
   endtask

   task automatic test_stall_redirect();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_3008, 1'b0});
      for (int i = 0; i < 3; i++)
         s.push_back('{1'b1, 1'b1, 2'd2, 1'b0, 16'h0000, 26'h000_0C40, 32'h0, 32'h0000_300C, 32'h0000_3008, 1'b0});
      s.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 16'h0000, 26'h000_0C40, 32'h0, 32'h0000_3100, 32'h0000_300C, 1'b0});
      foreach (s[i]) begin
         apply(s[i]);
         e = sb.pop_front();
         checks++; if (pc_F !== e.f) begin errors++; $display("FAIL stall_pc_F step%0d got=%h exp=%h", i, pc_F, e.f); end
         checks++; if (pc_D !== e.d) begin errors++; $display("FAIL stall_pc_D step%0d got=%h exp=%h", i, pc_D, e.d); end
      end
   endtask

   task automatic test_jr_align();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b1, 1'b0, 2'd3, 1'b0, 16'h0000, 26'h0, 32'h0000_3402, 32'h0000_3402, 32'h0000_3100, ALIGN_EN});
      s.push_back('{1'b1, 1'b0, 2'd3, 1'b0, 16'h0000, 26'h0, 32'h0000_4000, 32'h0000_4000, 32'h0000_3402, ALIGN_EN});
      s.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0000_0001, 32'h0000_4004, 32'h0000_4000, ALIGN_EN});
      s.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0000_0001, 32'h0000_4008, 32'h0000_4004, ALIGN_EN});
      s.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0000_0001, 32'h0000_3000, 32'h0000_0000, 1'b0});
      foreach (s[i]) begin
         apply(s[i]);
         e = sb.pop_front();
         checks++; if (pc_F !== e.f) begin errors++; $display("FAIL jr_pc_F step%0d got=%h exp=%h", i, pc_F, e.f); end
         checks++; if (pc_D !== e.d) begin errors++; $display("FAIL jr_pc_D step%0d got=%h exp=%h", i, pc_D, e.d); end
         checks++; if (pc_misalign !== e.mis) begin errors++; $display("FAIL jr_misalign step%0d got=%b exp=%b", i, pc_misalign, e.mis); end
      end
   endtask

   task automatic test_wrap();
      stim_t s[$];
      exp_t  e;
      s.push_back('{1'b1, 1'b0, 2'd3, 1'b0, 16'h0000, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3000, 1'b0});
      s.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0});
      s.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0000_0004, 32'h0000_0000, 1'b0});
      foreach (s[i]) begin
         apply(s[i]);
         e = sb.pop_front();
         checks++; if (pc_F !== e.f) begin errors++; $display("FAIL wrap_pc_F step%0d got=%h exp=%h", i, pc_F, e.f); end
         checks++; if (pc_D !== e.d) begin errors++; $display("FAIL wrap_pc_D step%0d got=%h exp=%h", i, pc_D, e.d); end
         checks++; if (pc8_D !== e.d + 32'd8) begin errors++; $display("FAIL wrap_pc8_D step%0d got=%h exp=%h", i, pc8_D, e.d + 32'd8); end
         checks++; if (pc_misalign !== e.mis) begin errors++; $display("FAIL wrap_misalign step%0d got=%b exp=%b", i, pc_misalign, e.mis); end
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_branch();
      test_stall_redirect();
      test_jr_align();
      test_wrap();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
